// File: rtl/rattlesnake_mem_responder_pkg.sv
// Shared widths and FSM encodings for the memory responder.
package rattlesnake_mem_responder_pkg;

  localparam int MEM_ADDR_BITS = 4;
  localparam int XLEN          = 32;
  localparam int XLEN_BYTES    = XLEN / 8;

  // One-hot so a corrupted state register is detectable and falls back to clear.
  typedef enum logic [1:0] {
    MEM_RSP_S_CLEAR = 2'b01,
    MEM_RSP_S_READY = 2'b10
  } mem_rsp_state_e;

endpackage

// File: rtl/rattlesnake_mem_bank.sv
// One byte lane of the responder RAM: single port, read-before-write,
// registered output that holds between reads and clears on reset.
module rattlesnake_mem_bank #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           din,
  input  logic                 we,
  input  logic                 re,
  output logic [7:0]           dout
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] dout_q, dout_d;

  // Output register loads only on a read; the read sees the pre-write word.
  always_comb begin
    dout_d = dout_q;
    if (srst)    dout_d = 8'h00;
    else if (re) dout_d = mem_q[addr];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= 8'h00;
    else        dout_q <= dout_d;
  end

  // Storage array; no reset, contents are owned by the clear FSM in the top.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
  end

  assign dout = dout_q;

endmodule

// File: rtl/rattlesnake_mem_responder.sv
// Memory-side responder: zero-fills the RAM after reset, then services
// byte-lane writes and 1-cycle-latency reads from the core's memory port.
module rattlesnake_mem_responder
  import rattlesnake_mem_responder_pkg::*;
#(
  parameter int                   ADDR_BITS      = MEM_ADDR_BITS,
  parameter int                   DATA_BITS      = XLEN,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic [ADDR_BITS-1:0]   mem_addr,
  input  logic                   mem_read_en,
  input  logic [DATA_BITS/8-1:0] mem_write_en,
  input  logic [DATA_BITS-1:0]   mem_write_data,
  output logic [DATA_BITS-1:0]   mem_read_data,
  output logic                   init_done,
  output logic                   req_during_init
);
  localparam int NUM_LANES = DATA_BITS / 8;
  localparam mem_rsp_state_e RST_STATE =
    CLEAR_ON_RESET ? MEM_RSP_S_CLEAR : MEM_RSP_S_READY;

  mem_rsp_state_e       state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 req_flag_q, req_flag_d;
  logic                 host_req;

  logic [ADDR_BITS-1:0]             bank_addr;
  logic [NUM_LANES-1:0][7:0]        bank_din;
  logic [NUM_LANES-1:0][7:0]        bank_dout;
  logic [NUM_LANES-1:0]             bank_we;
  logic                             bank_re;

  assign host_req = mem_read_en | (|mem_write_en);

  // State register, clear counter and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      req_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      req_flag_q  <= req_flag_d;
    end
  end

  // Next state: clear walks every address once, then stays ready until reset.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    req_flag_d  = req_flag_q;
    if (sync_reset) begin
      state_d     = RST_STATE;
      clr_cnt_d   = '0;
      init_done_d = 1'b0;
      req_flag_d  = 1'b0;
    end else begin
      case (state_q)
        MEM_RSP_S_CLEAR: begin
          clr_cnt_d  = clr_cnt_q + 1'b1;  // wraps to 0 exactly on the exit edge
          req_flag_d = req_flag_q | host_req;
          if (clr_cnt_q == '1) state_d = MEM_RSP_S_READY;
        end
        MEM_RSP_S_READY: state_d = MEM_RSP_S_READY;
        default: begin
          state_d   = MEM_RSP_S_CLEAR;
          clr_cnt_d = '0;
        end
      endcase
      init_done_d = (state_d == MEM_RSP_S_READY);
    end
  end

  // RAM port mux: clear pattern at the counter, or the host request.
  always_comb begin
    bank_addr = mem_addr;
    bank_din  = mem_write_data;
    bank_we   = '0;
    bank_re   = 1'b0;
    if (!sync_reset) begin
      case (state_q)
        MEM_RSP_S_CLEAR: begin
          bank_addr = clr_cnt_q;
          bank_din  = CLEAR_VALUE;
          bank_we   = '1;
        end
        MEM_RSP_S_READY: begin
          bank_we = mem_write_en;
          bank_re = mem_read_en;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rattlesnake_mem_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
      .clk   (clk),
      .rst_n (reset_n),
      .srst  (sync_reset),
      .addr  (bank_addr),
      .din   (bank_din[g]),
      .we    (bank_we[g]),
      .re    (bank_re),
      .dout  (bank_dout[g])
    );
  end

  assign mem_read_data   = bank_dout;
  assign init_done       = init_done_q;
  assign req_during_init = req_flag_q;

endmodule

// File: tb/tb_rattlesnake_mem_responder.sv
// Directed bench: behavioural model of the clearing responder checked every
// cycle, plus literal expectations at the interesting points.
module tb_rattlesnake_mem_responder;
  logic        clk, reset_n, sync_reset, sync_reset2;
  logic [3:0]  addr;
  logic        rd_en;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata2;
  logic        done, done2, flag, flag2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  rattlesnake_mem_responder #(.ADDR_BITS(4), .DATA_BITS(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .mem_addr(addr),
    .mem_read_en(rd_en), .mem_write_en(we), .mem_write_data(wdata),
    .mem_read_data(rdata), .init_done(done), .req_during_init(flag));

  rattlesnake_mem_responder #(.ADDR_BITS(4), .DATA_BITS(32), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset2), .mem_addr(addr),
    .mem_read_en(rd_en), .mem_write_en(we), .mem_write_data(wdata),
    .mem_read_data(rdata2), .init_done(done2), .req_during_init(flag2));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model of the clearing responder (dut, CLEAR_ON_RESET=1).
  logic [31:0] m_mem [16];
  logic [31:0] m_rd;
  bit          m_done, m_flag;
  int          m_clr_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || sync_reset) begin
      m_rd = 0; m_done = 0; m_flag = 0; m_clr_left = 16;
    end else if (m_clr_left > 0) begin
      if (rd_en || we != 0) m_flag = 1;
      m_mem[16 - m_clr_left] = 32'h0;
      m_clr_left--;
      if (m_clr_left == 0) m_done = 1;
    end else begin
      if (rd_en) m_rd = m_mem[addr];
      for (int i = 0; i < 4; i++)
        if (we[i]) m_mem[addr][8*i +: 8] = wdata[8*i +: 8];
      m_done = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_rd",   rdata, m_rd);
      chk("model_done", {31'b0, done}, {31'b0, m_done});
      chk("model_flag", {31'b0, flag}, {31'b0, m_flag});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] en);
    addr = a; wdata = d; we = en; step(); we = 0;
  endtask

  task automatic do_read(input logic [3:0] a);
    addr = a; rd_en = 1; step(); rd_en = 0;
  endtask

  task automatic run_clear(input string nm);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k >= 15) chk(nm, {31'b0, done}, (k == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset_n = 0; sync_reset = 0; sync_reset2 = 0;
    addr = 0; rd_en = 0; we = 0; wdata = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rd", rdata, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_flag", {31'b0, flag}, 32'd0);
    chk("rst_done2", {31'b0, done2}, 32'd0);
    chk_en = 1;

    // 1: clear takes exactly 16 edges; everything reads back zero.
    reset_n = 1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("clr1_done", {31'b0, done}, (k == 16) ? 32'd1 : 32'd0);
      if (k == 1) chk("cor0_done2", {31'b0, done2}, 32'd1);
    end
    for (int a = 0; a < 16; a++) begin
      do_read(a[3:0]);
      chk("clr1_read", rdata, 32'h0);
    end

    // 2: byte-lane partial write.
    do_write(4'd3, 32'hDEADBEEF, 4'hF);
    do_write(4'd3, 32'h0000AA00, 4'b0010);
    do_read(4'd3);
    chk("lane_write", rdata, 32'hDEADAAEF);

    // 3: read-before-write on the same address, then hold.
    do_write(4'd5, 32'h11223344, 4'hF);
    addr = 5; rd_en = 1; wdata = 32'h55667788; we = 4'hF; step(); rd_en = 0; we = 0;
    chk("rbw_old", rdata, 32'h11223344);
    do_read(4'd5);
    chk("rbw_new", rdata, 32'h55667788);
    step(); step();
    chk("rd_hold", rdata, 32'h55667788);

    // 5a: sync reset, then again at clear cycle 10; clear restarts from 0.
    sync_reset = 1; step(); sync_reset = 0;
    chk("srst_rd", rdata, 32'h0);
    chk("srst_done", {31'b0, done}, 32'd0);
    repeat (10) step();
    chk("srst_mid_done", {31'b0, done}, 32'd0);
    sync_reset = 1; step(); sync_reset = 0;
    run_clear("srst_clr_done");
    do_read(4'd3);
    chk("srst_cleared", rdata, 32'h0);

    // 5b: async reset pulse in ready clears outputs immediately.
    do_write(4'd2, 32'hCAFE0001, 4'hF);
    do_read(4'd2);
    chk("pre_arst_rd", rdata, 32'hCAFE0001);
    reset_n = 0; #2;
    chk("arst_rd", rdata, 32'h0);
    chk("arst_done", {31'b0, done}, 32'd0);
    step(); reset_n = 1;

    // 4: request during clear cycle 5 is ignored but flagged stickily.
    repeat (4) step();
    addr = 7; wdata = 32'hCAFEF00D; we = 4'hF; rd_en = 1; step(); we = 0; rd_en = 0;
    chk("init_req_flag", {31'b0, flag}, 32'd1);
    chk("init_req_rd", rdata, 32'h0);
    for (int k = 6; k <= 16; k++) begin
      step();
      if (k >= 15) chk("arst_clr_done", {31'b0, done}, (k == 16) ? 32'd1 : 32'd0);
    end
    chk("flag_sticky", {31'b0, flag}, 32'd1);
    do_read(4'd7);
    chk("init_req_nowrite", rdata, 32'h0);
    do_read(4'd2);
    chk("arst_cleared", rdata, 32'h0);

    // 6: CLEAR_ON_RESET=0 keeps contents across sync_reset.
    do_write(4'd9, 32'hA5A55A5A, 4'hF);
    sync_reset2 = 1; step(); sync_reset2 = 0;
    chk("cor0_srst_rd", rdata2, 32'h0);
    chk("cor0_srst_done", {31'b0, done2}, 32'd0);
    step();
    chk("cor0_done_after", {31'b0, done2}, 32'd1);
    do_read(4'd9);
    chk("cor0_keep", rdata2, 32'hA5A55A5A);
    chk("cor0_flag", {31'b0, flag2}, 32'd0);
    chk("dut1_rd9", rdata, 32'hA5A55A5A);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
